// File: rtl/synth_pkg.sv
// Shared defaults and types for the polyphonic voice allocator.
package synth_pkg;

    localparam int unsigned NUM_KEYS_DEF   = 12;
    localparam int unsigned NUM_VOICES_DEF = 4;

    typedef logic [$clog2(NUM_KEYS_DEF)-1:0]   key_idx_t;
    typedef logic [$clog2(NUM_VOICES_DEF)-1:0] voice_age_t;

endpackage

// File: rtl/lsb_priority_enc.sv
// Lowest-set-bit priority encoder: reports whether any request is set and the
// index of the lowest one.
module lsb_priority_enc #(
    parameter int unsigned  WIDTH = 8,
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] i_req,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Touch-key to voice allocator: lowest free voice takes the lowest unserved key.
// Optional macro VOICE_STEAL_EN lets a new press steal the oldest voice when none is free.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int unsigned  NUM_KEYS   = NUM_KEYS_DEF,
    parameter int unsigned  NUM_VOICES = NUM_VOICES_DEF,
    localparam int unsigned KEY_W      = $clog2(NUM_KEYS),
    localparam int unsigned CNT_W      = $clog2(NUM_VOICES + 1)
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [NUM_KEYS-1:0]         touch_status_in,
    output logic [NUM_VOICES-1:0]       voice_gate_out,
    output logic [NUM_VOICES-1:0]       voice_trigger_out,
    output logic [NUM_VOICES*KEY_W-1:0] voice_note_out,
    output logic [CNT_W-1:0]            active_count_out,
    output logic                        voices_full_out
);

    localparam int unsigned      VID_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned      AGE_W   = VID_W;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

    logic [NUM_KEYS-1:0]   r_touch, r_pending;
    logic [NUM_VOICES-1:0] r_gate, r_trig;
    logic [KEY_W-1:0]      r_note [NUM_VOICES];
    logic [AGE_W-1:0]      r_age  [NUM_VOICES];
    logic [CNT_W-1:0]      r_count;
    logic                  r_full;

    logic [NUM_KEYS-1:0]   w_assigned, w_cand, w_grant, w_pending_d, w_assigned_d;
    logic [NUM_VOICES-1:0] w_keep, w_gate_d, w_trig_d;
    logic [KEY_W-1:0]      w_note_d [NUM_VOICES];
    logic [AGE_W-1:0]      w_age_d  [NUM_VOICES];
    logic [CNT_W-1:0]      w_count_d;
    logic                  w_full_d;
    logic                  w_key_valid, w_free_valid, w_alloc;
    logic [KEY_W-1:0]      w_key_idx, w_key;
    logic [VID_W-1:0]      w_free_idx, w_tgt;

    // Voices keep their gate only while their key is still held.
    always_comb begin
        w_assigned = '0;
        w_keep     = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_keep[v] = r_gate[v] & r_touch[r_note[v]];
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (r_gate[v] && (r_note[v] == KEY_W'(k))) w_assigned[k] = 1'b1;
            end
        end
    end

    assign w_cand = r_touch & ~w_assigned;

    lsb_priority_enc #(.WIDTH(NUM_KEYS)) u_key_enc (
        .i_req   (w_cand),
        .o_valid (w_key_valid),
        .o_idx   (w_key_idx)
    );

    lsb_priority_enc #(.WIDTH(NUM_VOICES)) u_free_enc (
        .i_req   (~r_gate),
        .o_valid (w_free_valid),
        .o_idx   (w_free_idx)
    );

`ifdef VOICE_STEAL_EN
    logic             w_pend_valid, w_steal_found;
    logic [KEY_W-1:0] w_pend_idx;
    logic [VID_W-1:0] w_steal_v;
    logic [AGE_W-1:0] w_best_age;

    lsb_priority_enc #(.WIDTH(NUM_KEYS)) u_pend_enc (
        .i_req   (r_pending),
        .o_valid (w_pend_valid),
        .o_idx   (w_pend_idx)
    );
`endif

    always_comb begin
        w_alloc = w_key_valid & w_free_valid;
        w_tgt   = w_free_idx;
        w_key   = w_key_idx;
`ifdef VOICE_STEAL_EN
        // Oldest surviving voice, strict compare keeps the lowest index on ties.
        w_steal_found = 1'b0;
        w_steal_v     = '0;
        w_best_age    = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (w_keep[v] && (!w_steal_found || (r_age[v] > w_best_age))) begin
                w_steal_found = 1'b1;
                w_steal_v     = VID_W'(v);
                w_best_age    = r_age[v];
            end
        end
        if (!w_free_valid && w_pend_valid && w_steal_found) begin
            w_alloc = 1'b1;
            w_tgt   = w_steal_v;
            w_key   = w_pend_idx;
        end
`endif
    end

    always_comb begin
        w_grant = '0;
        if (w_alloc) w_grant[w_key] = 1'b1;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_gate_d[v] = w_keep[v];
            w_trig_d[v] = 1'b0;
            w_note_d[v] = r_note[v];
            w_age_d[v]  = r_age[v];
            if (w_alloc) begin
                if (w_tgt == VID_W'(v)) begin
                    w_gate_d[v] = 1'b1;
                    w_trig_d[v] = 1'b1;
                    w_note_d[v] = w_key;
                    w_age_d[v]  = '0;
                end else if (w_keep[v] && (r_age[v] != AGE_MAX)) begin
                    w_age_d[v] = r_age[v] + 1'b1;
                end
            end
        end
        // Pending tracks rising edges of the registered touch level.
        w_pending_d = touch_status_in & (~r_touch | (r_pending & ~w_grant));
    end

    // Status is computed from next state so it lines up with the registered gates.
    always_comb begin
        w_count_d    = '0;
        w_assigned_d = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (w_gate_d[v]) begin
                w_count_d = w_count_d + 1'b1;
                for (int k = 0; k < NUM_KEYS; k++) begin
                    if (w_note_d[v] == KEY_W'(k)) w_assigned_d[k] = 1'b1;
                end
            end
        end
        w_full_d = (&w_gate_d) & (|(touch_status_in & ~w_assigned_d));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_touch   <= '0;
            r_pending <= '0;
            r_gate    <= '0;
            r_trig    <= '0;
            r_note    <= '{default: '0};
            r_age     <= '{default: '0};
            r_count   <= '0;
            r_full    <= 1'b0;
        end else begin
            r_touch   <= touch_status_in;
            r_pending <= w_pending_d;
            r_gate    <= w_gate_d;
            r_trig    <= w_trig_d;
            r_note    <= w_note_d;
            r_age     <= w_age_d;
            r_count   <= w_count_d;
            r_full    <= w_full_d;
        end
    end

    always_comb begin
        voice_note_out = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_note_out[v*KEY_W +: KEY_W] = r_note[v];
        end
    end

    assign voice_gate_out    = r_gate;
    assign voice_trigger_out = r_trig;
    assign active_count_out  = r_count;
    assign voices_full_out   = r_full;

endmodule

// File: tb/tb_voice_allocator.sv
// Table-driven bench for voice_allocator (12 keys, 4 voices); expectations
// follow VOICE_STEAL_EN when that macro is defined.
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] touch = '0;
    logic [3:0]  gate, trig;
    logic [15:0] notes;
    logic [2:0]  cnt;
    logic        full;

    always #5 clk = ~clk;

    voice_allocator #(
        .NUM_KEYS   (12),
        .NUM_VOICES (4)
    ) dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .touch_status_in   (touch),
        .voice_gate_out    (gate),
        .voice_trigger_out (trig),
        .voice_note_out    (notes),
        .active_count_out  (cnt),
        .voices_full_out   (full)
    );

    typedef struct {
        logic        rst;
        logic [11:0] touch;
        logic [3:0]  gate;
        logic [3:0]  trig;
        logic [15:0] notes;
        logic [2:0]  cnt;
        logic        full;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input logic r, input logic [11:0] t, input logic [3:0] g,
                       input logic [3:0] tr, input logic [3:0] n0, input logic [3:0] n1,
                       input logic [3:0] n2, input logic [3:0] n3, input logic [2:0] c,
                       input logic f);
        vec_t x;
        x.rst   = r;
        x.touch = t;
        x.gate  = g;
        x.trig  = tr;
        x.notes = {n3, n2, n1, n0};
        x.cnt   = c;
        x.full  = f;
        vecs.push_back(x);
    endtask

    task automatic check(input string what, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h, expected %0h", what, row, act, exp);
        end
    endtask

    initial begin
        vec_t        e;
        logic [15:0] mask;
        int          edges;

        // Reset, single press and release latency.
        add(1, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
        add(1, 12'h008, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
        add(0, 12'h008, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
        add(0, 12'h008, 4'b0001, 4'b0001, 3, 0, 0, 0, 1, 0);
        add(0, 12'h008, 4'b0001, 4'b0000, 3, 0, 0, 0, 1, 0);
        add(0, 12'h000, 4'b0001, 4'b0000, 3, 0, 0, 0, 1, 0);
        add(0, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
        // Keys 1, 5, 9 together: one grant per cycle.
        add(0, 12'h222, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
        add(0, 12'h222, 4'b0001, 4'b0001, 1, 0, 0, 0, 1, 0);
        add(0, 12'h222, 4'b0011, 4'b0010, 1, 5, 0, 0, 2, 0);
        add(0, 12'h222, 4'b0111, 4'b0100, 1, 5, 9, 0, 3, 0);
        add(0, 12'h222, 4'b0111, 4'b0000, 1, 5, 9, 0, 3, 0);
        add(0, 12'h000, 4'b0111, 4'b0000, 1, 5, 9, 0, 3, 0);
        add(0, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
        // Keys 0-3 fill all voices, then key 7, then key 2 released.
        add(0, 12'h00F, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
        add(0, 12'h00F, 4'b0001, 4'b0001, 0, 0, 0, 0, 1, 0);
        add(0, 12'h00F, 4'b0011, 4'b0010, 0, 1, 0, 0, 2, 0);
        add(0, 12'h00F, 4'b0111, 4'b0100, 0, 1, 2, 0, 3, 0);
        add(0, 12'h00F, 4'b1111, 4'b1000, 0, 1, 2, 3, 4, 0);
        add(0, 12'h08F, 4'b1111, 4'b0000, 0, 1, 2, 3, 4, 1);
`ifdef VOICE_STEAL_EN
        add(0, 12'h08F, 4'b1111, 4'b0001, 7, 1, 2, 3, 4, 1);
        add(0, 12'h08B, 4'b1111, 4'b0000, 7, 1, 2, 3, 4, 1);
        add(0, 12'h08B, 4'b1011, 4'b0000, 7, 1, 0, 3, 3, 0);
        add(0, 12'h08B, 4'b1111, 4'b0100, 7, 1, 0, 3, 4, 0);
        add(0, 12'h000, 4'b1111, 4'b0000, 7, 1, 0, 3, 4, 0);
`else
        add(0, 12'h08F, 4'b1111, 4'b0000, 0, 1, 2, 3, 4, 1);
        add(0, 12'h08B, 4'b1111, 4'b0000, 0, 1, 2, 3, 4, 1);
        add(0, 12'h08B, 4'b1011, 4'b0000, 0, 1, 0, 3, 3, 0);
        add(0, 12'h08B, 4'b1111, 4'b0100, 0, 1, 7, 3, 4, 0);
        add(0, 12'h000, 4'b1111, 4'b0000, 0, 1, 7, 3, 4, 0);
`endif
        add(0, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
        // Keys 4-7 full, then release 5 and press 8 in one cycle.
        add(0, 12'h0F0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
        add(0, 12'h0F0, 4'b0001, 4'b0001, 4, 0, 0, 0, 1, 0);
        add(0, 12'h0F0, 4'b0011, 4'b0010, 4, 5, 0, 0, 2, 0);
        add(0, 12'h0F0, 4'b0111, 4'b0100, 4, 5, 6, 0, 3, 0);
        add(0, 12'h0F0, 4'b1111, 4'b1000, 4, 5, 6, 7, 4, 0);
        add(0, 12'h1D0, 4'b1111, 4'b0000, 4, 5, 6, 7, 4, 1);
`ifdef VOICE_STEAL_EN
        add(0, 12'h1D0, 4'b1101, 4'b0001, 8, 0, 6, 7, 3, 0);
        add(0, 12'h1D0, 4'b1111, 4'b0010, 8, 4, 6, 7, 4, 0);
        add(0, 12'h000, 4'b1111, 4'b0000, 8, 4, 6, 7, 4, 0);
`else
        add(0, 12'h1D0, 4'b1101, 4'b0000, 4, 0, 6, 7, 3, 0);
        add(0, 12'h1D0, 4'b1111, 4'b0010, 4, 8, 6, 7, 4, 0);
        add(0, 12'h000, 4'b1111, 4'b0000, 4, 8, 6, 7, 4, 0);
`endif
        add(0, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
        // One-cycle reset with three gated voices; held keys re-allocate.
        add(0, 12'h00E, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
        add(0, 12'h00E, 4'b0001, 4'b0001, 1, 0, 0, 0, 1, 0);
        add(0, 12'h00E, 4'b0011, 4'b0010, 1, 2, 0, 0, 2, 0);
        add(0, 12'h00E, 4'b0111, 4'b0100, 1, 2, 3, 0, 3, 0);
        add(1, 12'h00E, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
        add(0, 12'h00E, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);
        add(0, 12'h00E, 4'b0001, 4'b0001, 1, 0, 0, 0, 1, 0);
        add(0, 12'h00E, 4'b0011, 4'b0010, 1, 2, 0, 0, 2, 0);
        add(0, 12'h00E, 4'b0111, 4'b0100, 1, 2, 3, 0, 3, 0);
        add(0, 12'h000, 4'b0111, 4'b0000, 1, 2, 3, 0, 3, 0);
        add(0, 12'h000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst   = vecs[i].rst;
            touch = vecs[i].touch;
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e    = sb.pop_front();
            mask = '0;
            for (int v = 0; v < 4; v++) if (e.gate[v]) mask[v*4 +: 4] = 4'hF;
            check("gate",  i, 32'(gate),          32'(e.gate));
            check("trig",  i, 32'(trig),          32'(e.trig));
            check("notes", i, 32'(notes & mask),  32'(e.notes & mask));
            check("count", i, 32'(cnt),           32'(e.cnt));
            check("full",  i, 32'(full),          32'(e.full));
        end

        // Press key 10 from idle: trigger on voice 0 exactly two edges later, one cycle wide.
        @(negedge clk);
        touch = 12'h400;
        edges = 0;
        for (int t = 0; t < 8; t++) begin
            @(posedge clk);
            #1;
            edges++;
            if (trig[0]) break;
        end
        check("press_latency", 100, 32'(edges), 32'd2);
        check("press_note",    100, 32'(notes[3:0]), 32'd10);
        @(posedge clk);
        #1;
        check("trig_width",    101, 32'(trig), 32'd0);
        check("gate_hold",     101, 32'(gate), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_KEYS, default 12: number of touch keys; legal range 2..256.
REQ-002 Parameter NUM_VOICES, default 4: number of polyphonic voices; legal range 1..16.
REQ-003 Port clk_in  input  1: the single clock.
REQ-004 Port rst_in  input  1: reset, synchronous and active-high.
REQ-005 Port touch_status_in  input  NUM_KEYS: per-key held level; bit k high means key k is held.
REQ-006 Port voice_gate_out  output  NUM_VOICES: per-voice gate; high while the voice is allocated.
REQ-007 Port voice_trigger_out  output  NUM_VOICES: per-voice one-cycle pulse on each new allocation.
REQ-008 Port voice_note_out  output  NUM_VOICES*KEY_W: packed key index per voice, voice v at bits [v*KEY_W +: KEY_W], where KEY_W = $clog2(NUM_KEYS).
REQ-009 Port active_count_out  output  $clog2(NUM_VOICES+1): number of gated voices.
REQ-010 Port voices_full_out  output  1: high when all voices are gated and at least one held key has no voice.

Function
REQ-011 touch_status_in SHALL be registered once into touch_q; all decisions SHALL use touch_q and the registered voice state.
REQ-012 Each key SHALL have a pending flag: set on a 0->1 transition of touch_q[k]; cleared when key k is allocated or touch_q[k] is 0.
REQ-013 assigned[k] SHALL be high when any gated voice holds note k; a key SHALL never occupy more than one voice.
REQ-014 Release: every gated voice whose key has touch_q low SHALL drop its gate on the next edge; all such voices SHALL release in the same cycle.
REQ-015 Allocation SHALL grant at most one key per cycle, choosing the lowest-index key in (touch_q & ~assigned).
REQ-016 A free voice is the lowest-index voice whose gate is low at the start of the cycle; a voice released in cycle N SHALL NOT be reused before cycle N+1.
REQ-017 On allocation, the chosen voice SHALL load its gate = 1, note = key index and age = 0, and SHALL pulse voice_trigger_out for exactly one cycle, coincident with the first cycle its gate or new note is visible.
REQ-018 Each voice SHALL keep an age counter; on every allocation, all other gated voices SHALL increment their age, saturating at NUM_VOICES-1.
REQ-019 Latency: a key press at touch_status_in SHALL give gate and trigger 2 edges later when a voice is free; a key release SHALL drop the gate 2 edges later.
REQ-020 Held keys with no voice SHALL wait and SHALL be allocated, lowest index first, as voices free up.
REQ-021 voices_full_out and active_count_out SHALL be registered and SHALL reflect the voice state of the same cycle.
REQ-022 If a release and an allocation occur in one cycle, the release SHALL take effect and the allocation SHALL use only voices that were already free.

Reset
REQ-023 While rst_in is high, touch_q, pending, all gates, notes, ages and triggers SHALL be 0, active_count_out = 0 and voices_full_out = 0.
REQ-024 Keys still held when rst_in deasserts SHALL be treated as new presses, with pending set from touch_q.

Configuration
REQ-025 Macro VOICE_STEAL_EN: when defined and no voice is free, the lowest-index key with pending set SHALL steal the voice with the highest age (ties go to the lowest voice index).
REQ-026 On a steal, the gate SHALL stay high, the note and age SHALL update, the trigger SHALL pulse, and the displaced key SHALL be left waiting.
REQ-027 Without VOICE_STEAL_EN, no stealing SHALL occur and waiting keys SHALL be served only per REQ-020.

Structure
REQ-028 Package synth_pkg SHALL hold the NUM_KEYS and NUM_VOICES defaults and the key_idx_t and voice_age_t typedefs.
REQ-029 Sub-module lsb_priority_enc (parametrised width; outputs valid and index of the lowest set bit) SHALL be instantiated for key selection and free-voice selection.

Verification (NUM_KEYS=12, NUM_VOICES=4)
REQ-030 Press key 3 at cycle 0 -> at cycle 2, voice 0 gate = 1, note = 3, trigger pulses 1 cycle; active_count_out = 1.
REQ-031 Press keys 1, 5 and 9 in the same cycle -> voices 0/1/2 take notes 1/5/9 on 3 consecutive cycles, each with its own trigger pulse.
REQ-032 Hold keys 0-3, then press key 7 without VOICE_STEAL_EN -> voices_full_out = 1 and no trigger; release key 2 -> the freed voice takes note 7 one cycle after its release.
REQ-033 Same stimulus with VOICE_STEAL_EN -> voice 0 (oldest, note 0) gets note 7, gate stays 1, trigger pulses; key 0 then waits.
REQ-034 Assert rst_in for 1 cycle while 3 voices are gated -> all outputs are 0; held keys re-allocate after reset, starting 2 cycles later.
REQ-035 Release key 5 and press key 8 in the same cycle with all voices full -> key 8 gets no voice that cycle and takes the freed voice on the next cycle.
